// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic phase controller.
// Light encodings are {red, yellow, green} per phase.
package traffic_pkg;

  typedef enum logic [1:0] {
    ST_ALLRED = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_FLASH  = 2'd3
  } state_t;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  localparam logic [2:0] LIGHT_DARK   = 3'b000;

  // Ceiling log2; returns at least 1 so a 2-phase build still has a 1-bit index.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/traffic_phase_timer.sv
// Loadable down counter that saturates at zero; advances only on enabled ticks.
module traffic_phase_timer #(
  parameter int                   CNT_WIDTH = 8,
  parameter logic [CNT_WIDTH-1:0] RST_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 tick,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] value,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 zero
);

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= RST_VALUE;
    end else if (en) begin
      if (load) begin
        count_reg <= value;
      end else if (tick && (count_reg != '0)) begin
        count_reg <= count_reg - ONE;
      end
    end
  end

  assign count = count_reg;
  assign zero  = (count_reg == '0);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Multi-phase signal controller: GREEN -> YELLOW -> ALLRED rotation with phase skip,
// sticky pedestrian requests and a flashing-yellow fallback entered from ALLRED.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int NUM_PHASES  = 4,
  parameter int CNT_WIDTH   = 8,
  parameter int YELLOW_TIME = 3,
  parameter int ALLRED_TIME = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             tick,
  input  logic [NUM_PHASES*CNT_WIDTH-1:0]  green_time,
  input  logic [NUM_PHASES-1:0]            ped_req,
  input  logic                             flash_mode,
  output logic [3*NUM_PHASES-1:0]          light,
  output logic [clog2(NUM_PHASES)-1:0]     active_phase,
  output logic [CNT_WIDTH-1:0]             remain,
  output logic [NUM_PHASES-1:0]            ped_walk
);

  localparam int                   PW          = clog2(NUM_PHASES);
  localparam logic [CNT_WIDTH-1:0] ONE         = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] YELLOW_LOAD = CNT_WIDTH'(YELLOW_TIME - 1);
  localparam logic [CNT_WIDTH-1:0] ALLRED_LOAD = CNT_WIDTH'(ALLRED_TIME - 1);
  localparam logic [PW-1:0]        LAST_PHASE  = PW'(NUM_PHASES - 1);

  state_t                    state_reg, state_next;
  logic [PW-1:0]             active_reg, active_next;
  logic [NUM_PHASES-1:0]     walk_reg, walk_next;
  logic [NUM_PHASES-1:0]     latch_reg, latch_next;
  logic                      blink_reg, blink_next;
  logic [3*NUM_PHASES-1:0]   light_reg, light_next;

  logic                      timer_zero, timer_load;
  logic [CNT_WIDTH-1:0]      timer_value;
  logic                      done;

  logic [CNT_WIDTH-1:0]      green_dur [NUM_PHASES];
  logic [NUM_PHASES-1:0]     green_nz;
  logic [PW-1:0]             next_phase;
  logic                      next_found;

  generate
    for (genvar gi = 0; gi < NUM_PHASES; gi++) begin : g_dur
      assign green_dur[gi] = green_time[gi*CNT_WIDTH +: CNT_WIDTH];
      assign green_nz[gi]  = |green_dur[gi];
    end
  endgenerate

  // Rotate-priority search: first nonzero-duration phase after the active one,
  // with the active phase itself considered last.
  always_comb begin
    logic [PW-1:0] idx;
    next_phase = active_reg;
    next_found = 1'b0;
    idx        = '0;
    for (int k = 1; k <= NUM_PHASES; k++) begin
      idx = PW'((int'(active_reg) + k) % NUM_PHASES);
      if (!next_found && green_nz[idx]) begin
        next_found = 1'b1;
        next_phase = idx;
      end
    end
  end

  assign done = en & tick & timer_zero;

  always_comb begin
    state_next  = state_reg;
    active_next = active_reg;
    walk_next   = walk_reg;
    latch_next  = latch_reg | ped_req;
    blink_next  = blink_reg;
    timer_load  = 1'b0;
    timer_value = ALLRED_LOAD;
    case (state_reg)
      ST_ALLRED: begin
        if (done) begin
          timer_load = 1'b1;
          if (flash_mode) begin
            state_next  = ST_FLASH;
            timer_value = '0;
            blink_next  = 1'b0;
          end else if (next_found) begin
            state_next             = ST_GREEN;
            active_next            = next_phase;
            timer_value            = green_dur[next_phase] - ONE;
            walk_next              = '0;
            walk_next[next_phase]  = latch_reg[next_phase] | ped_req[next_phase];
            latch_next[next_phase] = 1'b0;
          end
        end
      end
      ST_GREEN: begin
        if (done) begin
          state_next  = ST_YELLOW;
          timer_load  = 1'b1;
          timer_value = YELLOW_LOAD;
          walk_next   = '0;
        end
      end
      ST_YELLOW: begin
        if (done) begin
          state_next  = ST_ALLRED;
          timer_load  = 1'b1;
          timer_value = ALLRED_LOAD;
        end
      end
      ST_FLASH: begin
        if (en && tick) begin
          blink_next = ~blink_reg;
          if (!flash_mode) begin
            state_next  = ST_ALLRED;
            timer_load  = 1'b1;
            timer_value = ALLRED_LOAD;
            blink_next  = 1'b0;
          end
        end
      end
      default: state_next = ST_ALLRED;
    endcase
  end

  // Lights are decoded from the next state so the output register lines up with the state.
  generate
    for (genvar gi = 0; gi < NUM_PHASES; gi++) begin : g_light
      always_comb begin
        light_next[3*gi +: 3] = LIGHT_RED;
        case (state_next)
          ST_GREEN:  light_next[3*gi +: 3] = (active_next == PW'(gi)) ? LIGHT_GREEN : LIGHT_RED;
          ST_YELLOW: light_next[3*gi +: 3] = (active_next == PW'(gi)) ? LIGHT_YELLOW : LIGHT_RED;
          ST_FLASH:  light_next[3*gi +: 3] = blink_next ? LIGHT_YELLOW : LIGHT_DARK;
          default:   light_next[3*gi +: 3] = LIGHT_RED;
        endcase
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_ALLRED;
      active_reg <= LAST_PHASE;
      walk_reg   <= '0;
      latch_reg  <= '0;
      blink_reg  <= 1'b0;
      light_reg  <= {NUM_PHASES{LIGHT_RED}};
    end else begin
      state_reg  <= state_next;
      active_reg <= active_next;
      walk_reg   <= walk_next;
      latch_reg  <= latch_next;
      blink_reg  <= blink_next;
      light_reg  <= light_next;
    end
  end

  traffic_phase_timer #(
    .CNT_WIDTH (CNT_WIDTH),
    .RST_VALUE (ALLRED_LOAD)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .tick  (tick),
    .load  (timer_load),
    .value (timer_value),
    .count (remain),
    .zero  (timer_zero)
  );

  assign light        = light_reg;
  assign active_phase = active_reg;
  assign ped_walk     = walk_reg;

endmodule
